// File: rtl/fifo1c_flex.sv
// Single-clock FIFO with registered or show-ahead read data, programmable
// almost-full/almost-empty flags, a high-watermark and sticky error flags.
module fifo1c_flex #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 7,
  parameter int SHOWAHEAD  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  input  logic                  flush,
  input  logic [ADDR_WIDTH:0]   aful_thres,
  input  logic [ADDR_WIDTH:0]   aemp_thres,
  input  logic                  highest_clr,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic [ADDR_WIDTH:0]   highest_dw,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wrPtr;
  logic [ADDR_WIDTH-1:0] r_rdPtr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_highest;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wrAccept;
  logic w_rdAccept;

  // Status comes only from the count register, never from this cycle's requests.
  assign w_full     = (r_count == LP_DEPTH);
  assign w_empty    = (r_count == '0);
  assign w_wrAccept = wrreq && !w_full;
  assign w_rdAccept = rdreq && !w_empty;

  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (r_count >= aful_thres);
  assign almost_empty = (r_count <= aemp_thres);
  assign usedw        = r_count;
  assign highest_dw   = r_highest;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_highest   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (flush) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
        r_count <= '0;
      end else begin
        if (w_wrAccept) r_wrPtr <= r_wrPtr + ADDR_WIDTH'(1);
        if (w_rdAccept) r_rdPtr <= r_rdPtr + ADDR_WIDTH'(1);
        case ({w_wrAccept, w_rdAccept})
          2'b10:   r_count <= r_count + (ADDR_WIDTH + 1)'(1);
          2'b01:   r_count <= r_count - (ADDR_WIDTH + 1)'(1);
          default: r_count <= r_count;
        endcase
      end
      if (wrreq && w_full)  r_overflow  <= 1'b1;
      if (rdreq && w_empty) r_underflow <= 1'b1;
      if (highest_clr) begin
        r_highest <= r_count;
      end else if (r_count > r_highest) begin
        r_highest <= r_count;
      end
    end
  end

  // Storage has no reset so it maps onto plain RAM; reset and flush block the write.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_wrAccept) begin
      r_mem[r_wrPtr] <= data;
    end
  end

  if (SHOWAHEAD != 0) begin : g_showahead
    assign q = w_empty ? '0 : r_mem[r_rdPtr];
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_q <= '0;
      end else if (w_rdAccept && !flush) begin
        r_q <= r_mem[r_rdPtr];
      end
    end

    assign q = r_q;
  end

endmodule
